// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared sizes and state type for the 1-to-512 bit scatter block
package demux_pkg;

  localparam int N_SLOTS = 512;
  localparam int SEL_W   = 9;
  localparam int CNT_W   = SEL_W + 1;

  // Count value at which the frame is complete.
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(N_SLOTS);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } scatter_state_t;

endpackage

// File: rtl/dec_onehot.sv
// rtl/dec_onehot.sv - enable-gated index to one-hot strobe decoder, mirror of the bit-select mux
module dec_onehot
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]   i_idx,
  input  logic               i_en,
  output logic [N_SLOTS-1:0] o_strobe
);

  // Exactly one strobe high when enabled, none otherwise.
  always_comb begin
    o_strobe = '0;
    if (i_en) begin
      o_strobe[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/demux512_scatter.sv
// rtl/demux512_scatter.sv - registered 1-to-512 bit demultiplexer assembling a frame from (slot, bit) beats
module demux512_scatter
  import demux_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [SEL_W-1:0]   i_in_sel,
  input  logic               i_in_bit,
  input  logic               i_in_last,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [N_SLOTS-1:0] o_out_bits,
  output logic [N_SLOTS-1:0] o_out_written,
  output logic [CNT_W-1:0]   o_out_count
);

  scatter_state_t     r_state;
  logic [N_SLOTS-1:0] r_bits;
  logic [N_SLOTS-1:0] r_written;
  logic [CNT_W-1:0]   r_count;

  logic               w_accept;
  logic [N_SLOTS-1:0] w_strobe;
  logic               w_prev_written;
  logic [CNT_W-1:0]   w_count_next;
  logic               w_close;

  // Handshake flags come straight from the state register so neither depends on an input.
  assign o_in_ready  = (r_state == FILL);
  assign o_out_valid = (r_state == HOLD);

  assign w_accept = i_in_valid & (r_state == FILL);

  // Pre-write written flag of the addressed slot decides whether the slot is new this frame.
  assign w_prev_written = r_written[i_in_sel];
  assign w_count_next   = r_count + {{(CNT_W-1){1'b0}}, ~w_prev_written};
  assign w_close        = i_in_last | (w_count_next == FULL_COUNT);

  dec_onehot u_dec (
    .i_idx    (i_in_sel),
    .i_en     (w_accept),
    .o_strobe (w_strobe)
  );

  // Frame state machine: fill slots from beats, then hold the frame until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FILL;
      r_bits    <= '0;
      r_written <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_bits    <= (r_bits & ~w_strobe) | (w_strobe & {N_SLOTS{i_in_bit}});
            r_written <= r_written | w_strobe;
            r_count   <= w_count_next;
            if (w_close) begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (i_out_ready) begin
            r_bits    <= '0;
            r_written <= '0;
            r_count   <= '0;
            r_state   <= FILL;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign o_out_bits    = r_bits;
  assign o_out_written = r_written;
  assign o_out_count   = r_count;

endmodule

// File: tb/tb_demux512_scatter.sv
// tb/tb_demux512_scatter.sv - directed self-checking bench for demux512_scatter
module tb_demux512_scatter;

  logic         clk;
  logic         rst_n;
  logic         i_in_valid;
  logic         o_in_ready;
  logic [8:0]   i_in_sel;
  logic         i_in_bit;
  logic         i_in_last;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [511:0] o_out_bits;
  logic [511:0] o_out_written;
  logic [9:0]   o_out_count;

  int checks;
  int failures;

  demux512_scatter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_in_sel      (i_in_sel),
    .i_in_bit      (i_in_bit),
    .i_in_last     (i_in_last),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_bits    (o_out_bits),
    .o_out_written (o_out_written),
    .o_out_count   (o_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_in_valid  = 1'b0;
    i_in_sel    = '0;
    i_in_bit    = 1'b0;
    i_in_last   = 1'b0;
    i_out_ready = 1'b0;
  endtask

  task automatic release_frame();
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++;
    if (o_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready_low got=%b want=1", o_in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got ready=%b valid=%b want ready=1 valid=0", o_in_ready, o_out_valid);
    end
    checks++;
    if (o_out_bits !== '0 || o_out_written !== '0 || o_out_count !== 10'd0) begin
      failures++;
      $display("FAIL reset_data got count=%0d bits_nz=%b written_nz=%b want all zero",
               o_out_count, |o_out_bits, |o_out_written);
    end
  endtask

  task automatic test_full_frame();
    logic [511:0] exp_bits;
    exp_bits = '0;
    for (int k = 0; k < 512; k++) begin
      i_in_valid = 1'b1;
      i_in_sel   = 9'(k);
      i_in_bit   = k[0];
      i_in_last  = 1'b0;
      exp_bits[k] = k[0];
      if (k == 511) begin
        checks++;
        if (o_out_count !== 10'd511 || o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
          failures++;
          $display("FAIL full_before_last got count=%0d valid=%b ready=%b want 511/0/1",
                   o_out_count, o_out_valid, o_in_ready);
        end
      end
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    checks++;
    if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_flags got valid=%b ready=%b want 1/0", o_out_valid, o_in_ready);
    end
    checks++;
    if (o_out_bits !== exp_bits || exp_bits !== {128{4'hA}}) begin
      failures++;
      $display("FAIL full_bits got=%h want=%h", o_out_bits, exp_bits);
    end
    checks++;
    if (o_out_written !== {512{1'b1}} || o_out_count !== 10'd512) begin
      failures++;
      $display("FAIL full_written_count got count=%0d all_written=%b want 512/1",
               o_out_count, &o_out_written);
    end
    release_frame();
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_out_count !== 10'd0 || o_out_bits !== '0) begin
      failures++;
      $display("FAIL full_release got valid=%b ready=%b count=%0d want 0/1/0",
               o_out_valid, o_in_ready, o_out_count);
    end
  endtask

  task automatic test_rewrite_and_hold();
    logic [511:0] exp_bits;
    logic [511:0] exp_written;
    exp_bits    = '0;
    exp_bits[300] = 1'b1;
    exp_written = '0;
    exp_written[5]   = 1'b1;
    exp_written[300] = 1'b1;
    // out_ready high during FILL must be ignored
    i_out_ready = 1'b1;
    i_in_valid = 1'b1; i_in_sel = 9'd5;   i_in_bit = 1'b1; i_in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (o_out_count !== 10'd1 || o_out_bits[5] !== 1'b1 || o_out_written[5] !== 1'b1) begin
      failures++;
      $display("FAIL rw_first_beat got count=%0d bit5=%b wr5=%b want 1/1/1",
               o_out_count, o_out_bits[5], o_out_written[5]);
    end
    i_in_sel = 9'd5;   i_in_bit = 1'b0; i_in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (o_out_count !== 10'd1 || o_out_bits[5] !== 1'b0) begin
      failures++;
      $display("FAIL rw_rewrite got count=%0d bit5=%b want 1/0", o_out_count, o_out_bits[5]);
    end
    i_out_ready = 1'b0;
    i_in_sel = 9'd300; i_in_bit = 1'b1; i_in_last = 1'b1;
    @(negedge clk);
    // keep pushing beats into HOLD; none may be taken
    i_in_sel = 9'd7; i_in_bit = 1'b1; i_in_last = 1'b0;
    checks++;
    if (o_out_valid !== 1'b1 || o_out_bits !== exp_bits || o_out_written !== exp_written || o_out_count !== 10'd2) begin
      failures++;
      $display("FAIL rw_frame got valid=%b count=%0d bits=%h written=%h want 1/2",
               o_out_valid, o_out_count, o_out_bits, o_out_written);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_out_bits !== exp_bits ||
          o_out_written !== exp_written || o_out_count !== 10'd2) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got valid=%b ready=%b count=%0d want 1/0/2",
                 c, o_out_valid, o_in_ready, o_out_count);
      end
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
    i_in_valid  = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_out_bits !== '0 || o_out_written !== '0 || o_out_count !== 10'd0) begin
      failures++;
      $display("FAIL hold_release got valid=%b count=%0d written_nz=%b want 0/0/0",
               o_out_valid, o_out_count, |o_out_written);
    end
    checks++;
    if (o_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_ready_return got=%b want=1", o_in_ready);
    end
  endtask

  task automatic test_async_reset();
    logic [511:0] exp_bits;
    for (int k = 0; k < 100; k++) begin
      i_in_valid = 1'b1; i_in_sel = 9'(k); i_in_bit = 1'b1; i_in_last = 1'b0;
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    checks++;
    if (o_out_count !== 10'd100) begin
      failures++;
      $display("FAIL async_pre_count got=%0d want=100", o_out_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_out_count !== 10'd0 || o_out_bits !== '0 || o_out_written !== '0 ||
        o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_clear got count=%0d ready=%b valid=%b want 0/1/0",
               o_out_count, o_in_ready, o_out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_bits = '0;
    for (int k = 0; k < 512; k++) begin
      i_in_valid = 1'b1; i_in_sel = 9'(511 - k); i_in_bit = k[1]; i_in_last = 1'b0;
      exp_bits[511 - k] = k[1];
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    checks++;
    if (o_out_valid !== 1'b1 || o_out_count !== 10'd512 || o_out_bits !== exp_bits) begin
      failures++;
      $display("FAIL async_refill got valid=%b count=%0d bits=%h want 1/512/%h",
               o_out_valid, o_out_count, o_out_bits, exp_bits);
    end
    release_frame();
  endtask

  task automatic test_single_beat();
    logic [511:0] exp_bits;
    exp_bits = '0;
    exp_bits[511] = 1'b1;
    i_in_valid = 1'b1; i_in_sel = 9'd511; i_in_bit = 1'b1; i_in_last = 1'b1;
    @(negedge clk);
    i_in_valid = 1'b0; i_in_last = 1'b0;
    checks++;
    if (o_out_valid !== 1'b1 || o_out_count !== 10'd1 || o_out_bits !== exp_bits || o_out_written !== exp_bits) begin
      failures++;
      $display("FAIL single_beat got valid=%b count=%0d bits=%h want 1/1/%h",
               o_out_valid, o_out_count, o_out_bits, exp_bits);
    end
    release_frame();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_frame();
    test_rewrite_and_hold();
    test_async_reset();
    test_single_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
